pipe_control: RTL

Pipeline control unit for the five-stage Y86-64 core. It sits beside the F/D/E/M/W pipeline registers and produces every stall and bubble strobe from the hazard conditions: load/use, `ret`, mispredicted `jXX`, and exception status. It also sequences the core through boot, run, pause and halt, and keeps wrapping performance counters readable by the testbench/debug shell.

---
 rtl/y86_pkg.sv | 26 ++
 rtl/pipe_hazard_detect.sv | 32 +++
 rtl/pipe_control.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, the "no register"
// ID and the pipeline-control state type.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational hazard terms for the five-stage pipeline: load/use, ret in
// flight, mispredicted branch, and exception in M or W.
module pipe_hazard_detect
    import y86_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] M_icode,
    input  logic [1:0] m_stat,
    input  logic [1:0] W_stat,
    output logic       lu,
    output logic       rt,
    output logic       mp,
    output logic       ex
);

    // REG_NONE guard keeps an absent destination from matching an absent source.
    assign lu = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                (E_dstM != REG_NONE) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));

    assign rt = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);

    assign mp = (E_icode == I_JXX) && !e_Cnd;

    assign ex = (m_stat != STAT_AOK) || (W_stat != STAT_AOK);

endmodule

// File: rtl/pipe_control.sv
// Y86-64 pipeline control: BOOT/RUN/HALTED sequencing, stall/bubble strobes
// derived from hazard terms, and wrapping performance counters.
module pipe_control
    import y86_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_en,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [1:0]       m_stat,
    input  logic [3:0]       W_icode,
    input  logic [1:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             E_stall,
    output logic             M_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             set_cc_en,
    output logic             halted,
    output logic [1:0]       halt_stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] loaduse_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    pc_state_e  state_q;
    logic       halted_q;
    logic [1:0] halt_stat_q;
    logic       lu, rt, mp, ex;
    logic       w_exc;
    logic       cnt_en;
    logic [3:0] cnt_inc;

    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    pipe_hazard_detect u_hazard (
        .D_icode (D_icode),
        .d_srcA  (d_srcA),
        .d_srcB  (d_srcB),
        .E_icode (E_icode),
        .E_dstM  (E_dstM),
        .e_Cnd   (e_Cnd),
        .M_icode (M_icode),
        .m_stat  (m_stat),
        .W_stat  (W_stat),
        .lu      (lu),
        .rt      (rt),
        .mp      (mp),
        .ex      (ex)
    );

    assign w_exc = (W_stat != STAT_AOK);

    always_comb begin
        F_stall   = 1'b0;
        D_stall   = 1'b0;
        E_stall   = 1'b0;
        M_stall   = 1'b0;
        W_stall   = 1'b0;
        D_bubble  = 1'b0;
        E_bubble  = 1'b0;
        M_bubble  = 1'b0;
        set_cc_en = 1'b0;
        case (state_q)
            ST_BOOT: begin
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
            end
            ST_RUN: begin
                if (run_en) begin
                    F_stall   = lu | rt;
                    D_stall   = lu;
                    D_bubble  = mp | (rt & ~lu);
                    E_bubble  = mp | lu;
                    M_bubble  = ex;
                    W_stall   = w_exc;
                    set_cc_en = (E_icode == I_OPQ) && !ex;
                end else begin
                    F_stall = 1'b1;
                    D_stall = 1'b1;
                    E_stall = 1'b1;
                    M_stall = 1'b1;
                    W_stall = 1'b1;
                end
            end
            default: begin
                F_stall = 1'b1;
                D_stall = 1'b1;
                E_stall = 1'b1;
                M_stall = 1'b1;
                W_stall = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            halted_q    <= 1'b0;
            halt_stat_q <= STAT_AOK;
        end else begin
            case (state_q)
                ST_BOOT: state_q <= ST_RUN;
                ST_RUN: begin
                    if (w_exc) begin
                        state_q     <= ST_HALTED;
                        halted_q    <= 1'b1;
                        halt_stat_q <= W_stat;
                    end
                end
                ST_HALTED: state_q <= ST_HALTED;
                default:   state_q <= ST_BOOT;
            endcase
        end
    end

    // The halting cycle itself (W_stat not AOK) is excluded from all counters.
    assign cnt_en  = (state_q == ST_RUN) && run_en && !w_exc;
    assign cnt_inc = {mp, lu, (W_icode != I_NOP), 1'b1};

    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
        assign cnt_d[gi] = (cnt_en && cnt_inc[gi]) ? (cnt_q[gi] + CNT_ONE) : cnt_q[gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[gi] <= '0;
            end else begin
                cnt_q[gi] <= cnt_d[gi];
            end
        end
    end

    assign halted      = halted_q;
    assign halt_stat   = halt_stat_q;
    assign cycle_cnt   = cnt_q[0];
    assign retired_cnt = cnt_q[1];
    assign loaduse_cnt = cnt_q[2];
    assign mispred_cnt = cnt_q[3];

endmodule
